rx_sequence_reader: RTL and testbench

- Sequencer for the 16x256 binary-sequence block RAM in the receive path.
- On a start request it reads RAM rows 0..SEQ_LEN-1 in order and extracts one selected column (bit position) from each row, so the column becomes a serial chip stream.
- The stream feeds the receive correlator / reference loader through a valid/ready handshake.
- It owns the RAM read port (enb, addrb) and absorbs the 1-cycle RAM read latency with an internal 2-entry buffer.

---
 rtl/rx_seq_pkg.sv | 38 +++
 rtl/rx_seq_skid_buf.sv | 45 ++++
 rtl/rx_sequence_reader.sv | 113 +++++++++++
 tb/tb_rx_sequence_reader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_seq_pkg.sv
// Shared constants, types and chip mapping for the receive sequence reader.
// RX_SEQ_READER_BIPOLAR_EN selects 2-bit bipolar chips instead of raw bits.
package rx_seq_pkg;
  localparam int SEQ_LEN = 255;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 16;
  localparam int SEL_W   = 4;

`ifdef RX_SEQ_READER_BIPOLAR_EN
  localparam int CHIP_W = 2;
`else
  localparam int CHIP_W = 1;
`endif

  localparam logic [1:0] CHIP_POS = 2'b01;
  localparam logic [1:0] CHIP_NEG = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic [CHIP_W-1:0] chip;
    logic [ADDR_W-1:0] idx;
    logic              last;
  } chip_ent_t;

  // RAM bit to output chip: raw bit, or +1/-1 in two's complement
  function automatic logic [CHIP_W-1:0] map_chip(input logic b);
`ifdef RX_SEQ_READER_BIPOLAR_EN
    return b ? CHIP_NEG : CHIP_POS;
`else
    return b;
`endif
  endfunction
endpackage

// File: rtl/rx_seq_skid_buf.sv
// Two-entry FIFO holding captured chips with their index and last flag.
module rx_seq_skid_buf
  import rx_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  chip_ent_t  din_i,
  output chip_ent_t  head_o,
  output logic [1:0] count_o
);
  chip_ent_t  mem_q [0:1];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q;
  logic       do_push, do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage and pointers; flush empties without touching stored payload
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/rx_sequence_reader.sv
// Streams one column of the sequence RAM (rows 0..SEQ_LEN-1) as serial chips.
// Optional macro RX_SEQ_READER_BIPOLAR_EN: 2-bit bipolar chip output.
module rx_sequence_reader
  import rx_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [SEL_W-1:0]  seq_sel,
  output logic              ram_enb,
  output logic [ADDR_W-1:0] ram_addrb,
  input  logic [DATA_W-1:0] ram_dob,
  output logic              chip_valid,
  input  logic              chip_ready,
  output logic [CHIP_W-1:0] chip,
  output logic [ADDR_W-1:0] chip_idx,
  output logic              chip_last,
  output logic              busy,
  output logic              done
);
  rx_state_e         state_q, state_d;
  logic [SEL_W-1:0]  sel_q;
  logic [ADDR_W-1:0] rd_addr_q, cap_idx_q;
  logic              rd_all_q;   // every row has been issued; keeps rd_addr from passing SEQ_LEN-1
  logic              inflight_q;
  logic              done_q, done_d;
  logic              issue, push, pop, flush, start_ok, last_hs;
  logic [1:0]        buf_cnt;
  logic [2:0]        occ;
  chip_ent_t         din, head;

  assign pop      = chip_valid && chip_ready;
  assign last_hs  = pop && head.last;
  assign occ      = {1'b0, buf_cnt} + {2'b0, inflight_q} - {2'b0, pop};
  // done_q blocks a start that lands in the completion cycle
  assign start_ok = start && (state_q == IDLE) && !done_q;
  assign flush    = abort && (state_q == STREAM);
  assign push     = inflight_q && (state_q == STREAM) && !abort;

  assign din = '{chip: map_chip(ram_dob[sel_q]),
                 idx:  cap_idx_q,
                 last: (cap_idx_q == ADDR_W'(SEQ_LEN - 1))};

  rx_seq_skid_buf u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (din),
    .head_o  (head),
    .count_o (buf_cnt)
  );

  // Next state, read issue and completion pulse
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    issue     = 1'b0;
    ram_enb   = 1'b0;
    ram_addrb = '0;
    case (state_q)
      IDLE:   if (start_ok) state_d = STREAM;
      STREAM: begin
        issue = !abort && !rd_all_q && (occ < 3'd2);
        if (abort) begin
          state_d = FLUSH;
        end else if (last_hs) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      FLUSH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ram_enb = issue;
    if (issue) ram_addrb = rd_addr_q;
  end

  // State, read address counter and capture tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      rd_addr_q  <= '0;
      rd_all_q   <= 1'b0;
      cap_idx_q  <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      inflight_q <= issue;
      if (issue) cap_idx_q <= rd_addr_q;
      if (start_ok) begin
        sel_q     <= seq_sel;
        rd_addr_q <= '0;
        rd_all_q  <= 1'b0;
      end else if (issue) begin
        if (rd_addr_q == ADDR_W'(SEQ_LEN - 1)) rd_all_q  <= 1'b1;
        else                                   rd_addr_q <= rd_addr_q + 1'b1;
      end
    end
  end

  assign chip_valid = (buf_cnt != 2'd0);
  assign chip       = head.chip;
  assign chip_idx   = head.idx;
  assign chip_last  = head.last;
  assign busy       = (state_q == STREAM);
  assign done       = done_q;
endmodule

// File: tb/tb_rx_sequence_reader.sv
// Directed bench for rx_sequence_reader with a behavioural sequence RAM.
module tb_rx_sequence_reader;
  import rx_seq_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n, start, abort, chip_ready;
  logic [SEL_W-1:0]  seq_sel;
  logic              ram_enb, chip_valid, chip_last, busy, done;
  logic [ADDR_W-1:0] ram_addrb, chip_idx;
  logic [DATA_W-1:0] ram_dob = '0;
  logic [CHIP_W-1:0] chip;
  logic [DATA_W-1:0] ram [0:255];

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  // 1-cycle latency read port
  always @(posedge clk) if (ram_enb) ram_dob <= ram[ram_addrb];

  rx_sequence_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .seq_sel(seq_sel),
    .ram_enb(ram_enb), .ram_addrb(ram_addrb), .ram_dob(ram_dob),
    .chip_valid(chip_valid), .chip_ready(chip_ready), .chip(chip),
    .chip_idx(chip_idx), .chip_last(chip_last), .busy(busy), .done(done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [CHIP_W-1:0] exp_chip(input logic b);
`ifdef RX_SEQ_READER_BIPOLAR_EN
    return b ? 2'b11 : 2'b01;
`else
    return b;
`endif
  endfunction

  // Results of the last stream run
  logic [CHIP_W-1:0] cap [0:SEQ_LEN-1];
  logic [CHIP_W-1:0] ref0 [0:SEQ_LEN-1];
  int hs_n, done_n, done_busy, first_vld, first_enb, last_hs_cyc, done_cyc;
  int hold_bad, last_bad, idx_bad, max_out, timed_out, late_enb, post_busy;
  int abort_cyc, rst_cyc, abort_vld, abort_busy, rst_zero;

  function automatic int mism(input logic [SEL_W-1:0] sel);
    int m = 0;
    for (int i = 0; i < SEQ_LEN; i++) if (cap[i] !== exp_chip(ram[i][sel])) m++;
    return m;
  endfunction

  function automatic int diff_ref0();
    int m = 0;
    for (int i = 0; i < SEQ_LEN; i++) if (cap[i] !== ref0[i]) m++;
    return m;
  endfunction

  // One run from start; optional random ready, abort/reset after N handshakes,
  // restart attempt with a changed seq_sel, and a start in the done cycle.
  task automatic stream(input logic [SEL_W-1:0] sel, input bit rnd, input int abort_hs,
                        input int rst_hs, input int busy_hs, input bit start_done);
    int out;
    logic pv, pr, pl, special, pspecial, hs;
    logic [CHIP_W-1:0] pc;
    logic [ADDR_W-1:0] pi;
    for (int i = 0; i < SEQ_LEN; i++) cap[i] = 'x;
    hs_n = 0; done_n = 0; done_busy = 0; first_vld = -1; first_enb = -1;
    last_hs_cyc = -1; done_cyc = -1; hold_bad = 0; last_bad = 0; idx_bad = 0;
    max_out = 0; timed_out = 1; late_enb = 0; post_busy = 0;
    abort_cyc = -1; rst_cyc = -1; abort_vld = -1; abort_busy = -1; rst_zero = -1;
    out = 0; pv = 0; pr = 0; pl = 0; pc = '0; pi = '0; pspecial = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      start = (cyc == 0); seq_sel = sel; abort = 1'b0; rst_n = 1'b1; special = 0;
      chip_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (start_done && last_hs_cyc >= 0 && cyc == last_hs_cyc + 1) start = 1'b1;
      if (busy_hs >= 0 && hs_n >= busy_hs) begin
        seq_sel = ~sel;
        if (hs_n == busy_hs) start = 1'b1;
      end
      if (abort_hs >= 0 && abort_cyc < 0 && hs_n == abort_hs) begin
        abort = 1'b1; chip_ready = 1'b0; special = 1; abort_cyc = cyc;
      end
      if (rst_hs >= 0 && rst_cyc < 0 && hs_n == rst_hs) begin
        rst_n = 1'b0; chip_ready = 1'b0; special = 1; rst_cyc = cyc;
      end
      @(negedge clk);
      if (ram_enb && first_enb < 0) first_enb = cyc;
      if (chip_valid && first_vld < 0) first_vld = cyc;
      if (done) begin
        done_n++;
        if (done_cyc < 0) done_cyc = cyc;
        if (busy) done_busy++;
      end
      if (done_cyc >= 0 && cyc > done_cyc && (busy || ram_enb)) post_busy++;
      if (abort_cyc >= 0 && cyc > abort_cyc && ram_enb) late_enb++;
      if (abort_cyc >= 0 && cyc == abort_cyc + 1) abort_vld = chip_valid;
      if (abort_cyc >= 0 && cyc == abort_cyc + 2) abort_busy = busy;
      if (rst_cyc >= 0 && cyc == rst_cyc + 1)
        rst_zero = (ram_enb | chip_valid | (|chip) | (|chip_idx) | chip_last |
                    busy | done | (|ram_addrb)) ? 0 : 1;
      if (pv && !pr && !pspecial &&
          !(chip_valid && chip == pc && chip_idx == pi && chip_last == pl)) hold_bad++;
      hs = chip_valid && chip_ready && !special;
      if (hs) begin
        if (chip_idx != ADDR_W'(hs_n)) idx_bad++;
        if (chip_last != (hs_n == SEQ_LEN - 1)) last_bad++;
        if (hs_n < SEQ_LEN) cap[hs_n] = chip;
        if (chip_last) last_hs_cyc = cyc;
        hs_n++;
      end
      out = special ? 0 : out + int'(ram_enb) - int'(hs);
      if (out > max_out) max_out = out;
      pv = chip_valid; pr = chip_ready; pc = chip; pi = chip_idx; pl = chip_last;
      pspecial = special;
      @(posedge clk); #1;
      if ((done_cyc >= 0 && cyc >= done_cyc + 3) ||
          (abort_cyc >= 0 && cyc >= abort_cyc + 6) ||
          (rst_cyc >= 0 && cyc >= rst_cyc + 6)) begin
        timed_out = 0;
        break;
      end
    end
    start = 1'b0; abort = 1'b0; chip_ready = 1'b0;
  endtask

  typedef struct {
    logic [SEL_W-1:0]  sel;
    int                idx;
    logic              bitv;
  } vec_t;

  vec_t vecs [6];
  logic [SEL_W-1:0] cur_sel;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'(i * 40503) ^ 16'(i << 7) ^ 16'h3C96;
    ram[0]   = 16'b0110001001101011;
    ram[1]   = 16'h9A54;
    ram[2]   = 16'hC3C3;
    ram[254] = 16'h7E3E;

    vecs[0] = '{sel: 4'd0,  idx: 0,   bitv: 1'b1};
    vecs[1] = '{sel: 4'd0,  idx: 1,   bitv: 1'b0};
    vecs[2] = '{sel: 4'd0,  idx: 254, bitv: 1'b0};
    vecs[3] = '{sel: 4'd15, idx: 0,   bitv: 1'b0};
    vecs[4] = '{sel: 4'd15, idx: 1,   bitv: 1'b1};
    vecs[5] = '{sel: 4'd15, idx: 2,   bitv: 1'b1};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; chip_ready = 1'b0; seq_sel = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_enb", ram_enb, 0);
    chk("rst_ram_addrb", ram_addrb, 0);
    chk("rst_chip_valid", chip_valid, 0);
    chk("rst_chip", chip, 0);
    chk("rst_chip_idx", chip_idx, 0);
    chk("rst_chip_last", chip_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full rate, column 0
    stream(4'd0, 0, -1, -1, -1, 0);
    chk("full_timeout", timed_out, 0);
    chk("full_first_enb", first_enb, 1);
    chk("full_first_valid", first_vld, 3);
    chk("full_handshakes", hs_n, SEQ_LEN);
    chk("full_last_hs_cycle", last_hs_cyc, 3 + SEQ_LEN - 1);
    chk("full_idx_order", idx_bad, 0);
    chk("full_last_flag", last_bad, 0);
    chk("full_done_cycle", done_cyc, 3 + SEQ_LEN);
    chk("full_done_count", done_n, 1);
    chk("full_busy_at_done", done_busy, 0);
    chk("full_model", mism(4'd0), 0);
    for (int i = 0; i < SEQ_LEN; i++) ref0[i] = cap[i];
    cur_sel = 4'd0;

    // Hand-computed chip table; the column-15 run also fires start in the done cycle
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].sel != cur_sel) begin
        stream(vecs[v].sel, 0, -1, -1, -1, 1);
        chk("sel15_timeout", timed_out, 0);
        chk("sel15_done_count", done_n, 1);
        chk("start_in_done_ignored", post_busy, 0);
        chk("sel15_model", mism(vecs[v].sel), 0);
        cur_sel = vecs[v].sel;
      end
      chk($sformatf("table_sel%0d_idx%0d", vecs[v].sel, vecs[v].idx),
          cap[vecs[v].idx], exp_chip(vecs[v].bitv));
    end

    // Random backpressure
    stream(4'd0, 1, -1, -1, -1, 0);
    chk("bp_timeout", timed_out, 0);
    chk("bp_handshakes", hs_n, SEQ_LEN);
    chk("bp_same_as_full", diff_ref0(), 0);
    chk("bp_hold_stable", hold_bad, 0);
    chk("bp_max_outstanding_le2", (max_out <= 2) ? 1 : 0, 1);
    chk("bp_done_count", done_n, 1);

    // Abort after 100 handshakes, then a fresh run on column 3
    stream(4'd0, 0, 100, -1, -1, 0);
    chk("abort_timeout", timed_out, 0);
    chk("abort_handshakes", hs_n, 100);
    chk("abort_valid_next", abort_vld, 0);
    chk("abort_busy_2cyc", abort_busy, 0);
    chk("abort_no_done", done_n, 0);
    chk("abort_no_reads", late_enb, 0);
    stream(4'd3, 0, -1, -1, -1, 0);
    chk("after_abort_first_valid", first_vld, 3);
    chk("after_abort_idx_order", idx_bad, 0);
    chk("after_abort_model", mism(4'd3), 0);
    chk("after_abort_done", done_n, 1);

    // Start and seq_sel change while busy
    stream(4'd5, 0, -1, -1, 50, 0);
    chk("busy_start_timeout", timed_out, 0);
    chk("busy_start_handshakes", hs_n, SEQ_LEN);
    chk("busy_start_model", mism(4'd5), 0);
    chk("busy_start_done", done_n, 1);
    chk("busy_start_last_cycle", last_hs_cyc, 3 + SEQ_LEN - 1);

    // Reset mid-stream at idx 120, then a clean run
    stream(4'd7, 0, -1, 120, -1, 0);
    chk("midrst_timeout", timed_out, 0);
    chk("midrst_outputs_zero", rst_zero, 1);
    chk("midrst_no_done", done_n, 0);
    stream(4'd7, 0, -1, -1, -1, 0);
    chk("after_rst_first_valid", first_vld, 3);
    chk("after_rst_model", mism(4'd7), 0);
    chk("after_rst_done", done_n, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
